seq_arith_100b_popcount_expand: RTL
===================================

// Module: seq_arith_100b_popcount_expand
//
// PURPOSE
// - Inverse of the 100-bit popcount: takes a count K and builds a 100-bit
//   thermometer vector with exactly K ones in bits [K-1:0], all other bits zero.
// - Builds the vector CHUNK bits per cycle. Input and output each use a
//   val/rdy handshake.
// - Sits ahead of the popcount datapath as a mask generator, and as a
//   stimulus source for popcount loopback checks.
//
// PARAMETERS
// - NBITS  default 100  width of the generated vector; must be a multiple of CHUNK
// - CHUNK  default 10   bits written per BUILD cycle
// - CW     default 7    count width, $clog2(NBITS+1); derived, do not override
//
// PORTS
// - clk        in   1      clock; all state changes on the rising edge
// - reset_n    in   1      asynchronous active-low reset
// - in_val     in   1      count request valid
// - in_rdy     out  1      block can accept a request
// - in_count   in   CW     requested number of ones K (0..2^CW-1)
// - out_val    out  1      generated vector valid
// - out_rdy    in   1      consumer accepts the vector
// - out_       out  NBITS  thermometer vector
// - out_count  out  CW     effective K (after clamping); valid with out_val
// - out_ovf    out  1      request exceeded NBITS; only with POPCOUNT_EXPAND_OVF_EN
//
// BEHAVIOUR
// - Reset values (async assert, released on deassert):
//   - state=IDLE, in_rdy=1, out_val=0, out_=0, out_count=0, out_ovf=0.
// - FSM states: IDLE -> BUILD -> DONE -> IDLE.
// - IDLE:
//   - in_rdy=1, out_val=0.
//   - On the edge where in_val && in_rdy: latch Keff=min(in_count, NBITS);
//     chunk index c=0; go to BUILD.
// - BUILD:
//   - in_rdy=0, out_val=0.
//   - Each edge writes out_[c*CHUNK +: CHUNK]; bit i of that slice is 1 iff
//     (c*CHUNK+i) < Keff. Then c increments.
//   - After chunk NBITS/CHUNK-1 is written, go to DONE.
//   - Chunks not yet written hold stale data; out_ is only meaningful while out_val=1.
// - DONE:
//   - out_val=1; out_, out_count=Keff and out_ovf are held stable.
//   - On the edge where out_rdy=1: go to IDLE.
//   - in_rdy=0 in DONE; no new request is accepted in the same cycle as output acceptance.
// - Latency:
//   - out_val rises exactly NBITS/CHUNK cycles after the accept edge (10 by default).
//   - Latency is fixed for all K, including K=0 and K>=NBITS.
//   - Minimum turnaround is NBITS/CHUNK+2 cycles per request.
// - Width and arithmetic rules:
//   - Comparisons are unsigned and done in CW+1 bits, so chunk offsets cannot wrap.
//   - K=0 gives all zeros; K=NBITS gives all ones.
//   - K>NBITS clamps to NBITS (all ones), out_count=NBITS.
// - Backpressure: while out_rdy=0 in DONE, all outputs stay stable indefinitely.
// - in_val is ignored outside IDLE. in_count is sampled only on the accept edge.
// - Reset mid-BUILD or mid-DONE: aborts immediately; returns to reset values;
//   the pending result is discarded.
// - Invariant: when out_val=1, popcount(out_) == out_count.
//
// CONFIGURATION
// - POPCOUNT_EXPAND_OVF_EN defined:
//   - out_ovf port exists.
//   - out_ovf is latched on accept as (in_count > NBITS) and held through DONE.
//   - out_ovf clears on return to IDLE.
// - POPCOUNT_EXPAND_OVF_EN undefined:
//   - out_ovf port and its flop are absent.
//   - Clamping behaviour is identical; overflow is silent.
//
// TESTING
// - Reset: hold reset_n=0 for 3 cycles -> in_rdy=1, out_val=0, out_=0.
//   Assert reset_n=0 asynchronously mid-cycle -> outputs reach reset values
//   before the next edge.
// - K=37, out_rdy=1:
//   - accept at edge E -> out_val=1 after edge E+10;
//   - out_[36:0] all ones, out_[99:37] all zeros, out_count=37;
//   - back in IDLE one cycle later.
// - Sweep K=0,1,9,10,11,99,100 -> out_ matches ((1<<K)-1); popcount(out_)==K;
//   no off-by-one at chunk edges 9/10/11.
// - K=127 -> out_ all ones, out_count=100; out_ovf=1 with the macro defined,
//   port absent without it.
// - Backpressure: K=50, out_rdy=0 for 20 cycles:
//   - out_val stays 1, out_ and out_count stay stable;
//   - in_val=1 with in_count=5 during this time is not accepted (in_rdy=0).
//   - Release out_rdy -> IDLE, then K=5 is accepted.
// - Mid-build reset and loopback:
//   - Pulse reset_n low 4 cycles after accepting K=60 -> no out_val is ever
//     produced for that request.
//   - Next request K=8 completes normally.
//   - Random loopback of 1000 values of K through the popcount block -> count matches.

Source files
------------

// File: rtl/seq_arith_100b_popcount_expand.sv
// Turns a count K into an NBITS-wide thermometer vector (K low bits set), CHUNK bits per cycle.
// Defining POPCOUNT_EXPAND_OVF_EN adds the out_ovf port flagging requests above NBITS.
module seq_arith_100b_popcount_expand #(
  parameter int NBITS = 100,
  parameter int CHUNK = 10,
  parameter int CW    = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [CW-1:0]    in_count,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_,
  output logic [CW-1:0]    out_count
`ifdef POPCOUNT_EXPAND_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NCHUNK = NBITS / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_C  = IW'(NCHUNK - 1);
  localparam logic [CW:0]   NBITS_W = (CW + 1)'(NBITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_rdy_q, in_rdy_d;
  logic             out_val_q, out_val_d;
  logic [CW-1:0]    keff_q, keff_d;
  logic [IW-1:0]    chunk_q, chunk_d;
  logic [NBITS-1:0] vec_q, vec_d;
  logic             over_s;

  // Rewrites only the bits of chunk c; widened compare keeps bit offsets from wrapping.
  function automatic logic [NBITS-1:0] fill_chunk(input logic [NBITS-1:0] vec,
                                                  input logic [IW-1:0]    c,
                                                  input logic [CW-1:0]    keff);
    logic [NBITS-1:0] r;
    r = vec;
    for (int j = 0; j < NBITS; j++) begin
      if (IW'(j / CHUNK) == c) begin
        r[j] = ((CW + 1)'(j) < {1'b0, keff});
      end else begin
        r[j] = vec[j];
      end
    end
    return r;
  endfunction

  assign over_s = ({1'b0, in_count} > NBITS_W);

`ifdef POPCOUNT_EXPAND_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow flag: captured on accept, dropped when the result is consumed.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && in_val && in_rdy_q) begin
      ovf_d = over_s;
    end else if (state_q == DONE && out_rdy) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`endif

  // Next-state and registered-output logic for IDLE -> BUILD -> DONE.
  always_comb begin
    state_d   = state_q;
    in_rdy_d  = in_rdy_q;
    out_val_d = out_val_q;
    keff_d    = keff_q;
    chunk_d   = chunk_q;
    vec_d     = vec_q;
    case (state_q)
      IDLE: begin
        if (in_val && in_rdy_q) begin
          state_d  = BUILD;
          in_rdy_d = 1'b0;
          chunk_d  = {IW{1'b0}};
          keff_d   = over_s ? CW'(NBITS) : in_count;
        end else begin
          state_d  = IDLE;
          in_rdy_d = 1'b1;
        end
      end
      BUILD: begin
        vec_d = fill_chunk(vec_q, chunk_q, keff_q);
        if (chunk_q == LAST_C) begin
          state_d   = DONE;
          out_val_d = 1'b1;
          chunk_d   = {IW{1'b0}};
        end else begin
          chunk_d = chunk_q + IW'(1);
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_d   = IDLE;
          out_val_d = 1'b0;
          in_rdy_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d   = IDLE;
        in_rdy_d  = 1'b1;
        out_val_d = 1'b0;
        chunk_d   = {IW{1'b0}};
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      in_rdy_q  <= 1'b1;
      out_val_q <= 1'b0;
      keff_q    <= {CW{1'b0}};
      chunk_q   <= {IW{1'b0}};
      vec_q     <= {NBITS{1'b0}};
    end else begin
      state_q   <= state_d;
      in_rdy_q  <= in_rdy_d;
      out_val_q <= out_val_d;
      keff_q    <= keff_d;
      chunk_q   <= chunk_d;
      vec_q     <= vec_d;
    end
  end

  assign in_rdy    = in_rdy_q;
  assign out_val   = out_val_q;
  assign out_      = vec_q;
  assign out_count = keff_q;

endmodule
